// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared widths, aluop codes and FSM encoding for the memory-access stage
package mem_access_pkg;

  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALUOP_W    = 8;

  localparam logic             RST_ENABLE = 1'b1;
  localparam logic [REG_W-1:0] ZERO_WORD  = '0;

  localparam logic [ALUOP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [ALUOP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [ALUOP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [ALUOP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [ALUOP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [ALUOP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [ALUOP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [ALUOP_W-1:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic logic is_load_op(input logic [ALUOP_W-1:0] op);
    return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
           (op == EXE_LHU_OP) || (op == EXE_LW_OP);
  endfunction

  function automatic logic is_mem_op(input logic [ALUOP_W-1:0] op);
    return is_load_op(op) || (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

endpackage

// File: rtl/mem_lane.sv
// rtl/mem_lane.sv - big-endian byte-lane select, store replication and load extension
module mem_lane
  import mem_access_pkg::*;
(
  input  logic [ALUOP_W-1:0] aluop,
  input  logic [1:0]         addr_lo,
  input  logic [REG_W-1:0]   reg2,
  input  logic [REG_W-1:0]   rdata,
  output logic [3:0]         sel,
  output logic [REG_W-1:0]   wdata,
  output logic [REG_W-1:0]   load_data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    lane_byte = rdata[31:24];
    case (addr_lo)
      2'b00:   lane_byte = rdata[31:24];
      2'b01:   lane_byte = rdata[23:16];
      2'b10:   lane_byte = rdata[15:8];
      default: lane_byte = rdata[7:0];
    endcase
    lane_half = addr_lo[1] ? rdata[15:0] : rdata[31:16];
  end

  always_comb begin
    sel       = 4'b0000;
    wdata     = ZERO_WORD;
    load_data = ZERO_WORD;
    case (aluop)
      EXE_LB_OP: begin
        sel       = 4'b1000 >> addr_lo;
        load_data = {{24{lane_byte[7]}}, lane_byte};
      end
      EXE_LBU_OP: begin
        sel       = 4'b1000 >> addr_lo;
        load_data = {24'b0, lane_byte};
      end
      EXE_LH_OP: begin
        sel       = addr_lo[1] ? 4'b0011 : 4'b1100;
        load_data = {{16{lane_half[15]}}, lane_half};
      end
      EXE_LHU_OP: begin
        sel       = addr_lo[1] ? 4'b0011 : 4'b1100;
        load_data = {16'b0, lane_half};
      end
      EXE_LW_OP: begin
        sel       = 4'b1111;
        load_data = rdata;
      end
      EXE_SB_OP: begin
        sel   = 4'b1000 >> addr_lo;
        wdata = {4{reg2[7:0]}};
      end
      EXE_SH_OP: begin
        sel   = addr_lo[1] ? 4'b0011 : 4'b1100;
        wdata = {2{reg2[15:0]}};
      end
      EXE_SW_OP: begin
        sel   = 4'b1111;
        wdata = reg2;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM pipeline stage: passthrough or stalled multi-cycle data-bus access
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] ex_wd,
  input  logic                  ex_wreg,
  input  logic [REG_W-1:0]      ex_wdata,
  input  logic                  ex_whilo,
  input  logic [REG_W-1:0]      ex_hi,
  input  logic [REG_W-1:0]      ex_lo,
  input  logic [ALUOP_W-1:0]    ex_aluop,
  input  logic [REG_W-1:0]      ex_mem_addr,
  input  logic [REG_W-1:0]      ex_reg2,
  output logic [REG_ADDR_W-1:0] mem_wd,
  output logic                  mem_wreg,
  output logic [REG_W-1:0]      mem_wdata,
  output logic                  mem_whilo,
  output logic [REG_W-1:0]      mem_hi,
  output logic [REG_W-1:0]      mem_lo,
  output logic                  stallreq,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [REG_W-1:0]      bus_addr,
  output logic [3:0]            bus_sel,
  output logic [REG_W-1:0]      bus_wdata,
  input  logic [REG_W-1:0]      bus_rdata,
  input  logic                  bus_ack,
  output logic                  bus_err
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             bus_req_q, bus_req_d;
  logic             bus_we_q, bus_we_d;
  logic             bus_err_q, bus_err_d;
  logic [3:0]       bus_sel_q, bus_sel_d;
  logic [REG_W-1:0] bus_addr_q, bus_addr_d;
  logic [REG_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [REG_W-1:0] rdata_q, rdata_d;

  logic             mem_op, load_op, stall;
  logic [3:0]       lane_sel;
  logic [REG_W-1:0] lane_wdata, lane_load;

  assign mem_op  = is_mem_op(ex_aluop);
  assign load_op = is_load_op(ex_aluop);

  mem_lane u_lane (
    .aluop     (ex_aluop),
    .addr_lo   (ex_mem_addr[1:0]),
    .reg2      (ex_reg2),
    .rdata     (bus_rdata),
    .sel       (lane_sel),
    .wdata     (lane_wdata),
    .load_data (lane_load)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_err_q   <= 1'b0;
      bus_sel_q   <= 4'b0000;
      bus_addr_q  <= ZERO_WORD;
      bus_wdata_q <= ZERO_WORD;
      rdata_q     <= ZERO_WORD;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_err_q   <= bus_err_d;
      bus_sel_q   <= bus_sel_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_err_d   = 1'b0;
    bus_sel_d   = bus_sel_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    stall       = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          stall       = 1'b1;
          state_d     = BUSY;
          cnt_d       = '0;
          bus_req_d   = 1'b1;
          bus_we_d    = ~load_op;
          bus_addr_d  = {ex_mem_addr[REG_W-1:2], 2'b00};
          bus_sel_d   = lane_sel;
          bus_wdata_d = lane_wdata;
        end
      end
      BUSY: begin
        stall = 1'b1;
        cnt_d = cnt_q + 8'd1;
        // ack takes priority over a timeout landing on the same cycle
        if (bus_ack) begin
          rdata_d   = lane_load;
          bus_req_d = 1'b0;
          state_d   = DONE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          rdata_d   = ZERO_WORD;
          bus_req_d = 1'b0;
          bus_err_d = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // stall drops with reset asserted even while a memory op is still presented
  assign stallreq = stall && (rst != RST_ENABLE);

  always_comb begin
    mem_wd    = ex_wd;
    mem_wreg  = ex_wreg;
    mem_whilo = ex_whilo;
    mem_hi    = ex_hi;
    mem_lo    = ex_lo;
    mem_wdata = ex_wdata;
    if (state_q == DONE && load_op) begin
      mem_wdata = rdata_q;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_err   = bus_err_q;
  assign bus_sel   = bus_sel_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - scoreboard testbench for the memory-access stage
module tb_mem_access;
  import mem_access_pkg::*;

  localparam logic [7:0] ADDU = 8'b0010_0001;
  localparam logic [7:0] NOP  = 8'h00;

  logic        clk, rst;
  logic [4:0]  ex_wd, mem_wd;
  logic        ex_wreg, mem_wreg, ex_whilo, mem_whilo;
  logic [31:0] ex_wdata, ex_hi, ex_lo, ex_mem_addr, ex_reg2;
  logic [31:0] mem_wdata, mem_hi, mem_lo;
  logic [7:0]  ex_aluop;
  logic        stallreq, bus_req, bus_we, bus_ack, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_sel;

  logic ex_valid;
  int   n_vec  = 0;
  int   n_miss = 0;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  mem_access #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr),
    .ex_reg2(ex_reg2),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_whilo(mem_whilo),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .stallreq(stallreq),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: an instruction completes on any sampled cycle where it is not stalled
  always @(negedge clk) begin
    if (!rst && ex_valid && !stallreq) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL sb_empty: output wdata=%h with no expectation queued", mem_wdata);
      end else begin
        mon_e = sb_q.pop_front();
        check32("mem_wdata", mem_wdata, mon_e.wdata);
        check32("mem_wd", 32'(mem_wd), 32'(mon_e.wd));
        check32("mem_wreg", 32'(mem_wreg), 32'(mon_e.wreg));
      end
    end
  end

  task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                        input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                        input int waits, input logic [31:0] rdata, input logic [31:0] exp_wdata,
                        input logic exp_we, input logic [31:0] exp_addr, input logic [3:0] exp_sel,
                        input logic [31:0] exp_bwdata, input int exp_stall, input int exp_breq,
                        input logic exp_err);
    int stalls = 0;
    int breqs  = 0;
    bit done   = 0;
    @(posedge clk);
    #1;
    ex_aluop = op; ex_mem_addr = addr; ex_reg2 = reg2;
    ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata; ex_valid = 1'b1;
    sb_q.push_back('{wd: wd, wreg: wreg, wdata: exp_wdata});
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      bus_ack   = 1'b0;
      bus_rdata = 32'hDEAD_BEEF;
      if (!stallreq) begin
        done = 1;
      end else begin
        stalls++;
        if (i == 0) check32("bus_err_idle", 32'(bus_err), 32'd0);
        if (bus_req) begin
          breqs++;
          check32("bus_addr", bus_addr, exp_addr);
          check32("bus_sel", 32'(bus_sel), 32'(exp_sel));
          check32("bus_we", 32'(bus_we), 32'(exp_we));
          if (exp_we) check32("bus_wdata", bus_wdata, exp_bwdata);
          if (breqs == waits + 1) begin
            bus_ack   = 1'b1;
            bus_rdata = rdata;
          end
        end
      end
    end
    bus_ack = 1'b0;
    if (!done) begin
      n_vec++;
      n_miss++;
      $display("FAIL op_timeout: stall still %b after 300 cycles, required release", stallreq);
    end
    check32("bus_req_done", 32'(bus_req), 32'd0);
    check32("bus_err_done", 32'(bus_err), 32'(exp_err));
    check32("bus_req_cycles", 32'(breqs), 32'(exp_breq));
    if (exp_stall >= 0) check32("stall_cycles", 32'(stalls), 32'(exp_stall));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int breqs;
    rst = 1'b1; ex_valid = 1'b0;
    ex_wd = '0; ex_wreg = 1'b0; ex_wdata = '0; ex_whilo = 1'b0;
    ex_hi = 32'h1111_2222; ex_lo = 32'h3333_4444;
    ex_aluop = NOP; ex_mem_addr = '0; ex_reg2 = '0;
    bus_rdata = '0; bus_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check32("rst_bus_req", 32'(bus_req), 32'd0);
    check32("rst_bus_we", 32'(bus_we), 32'd0);
    check32("rst_bus_err", 32'(bus_err), 32'd0);
    check32("rst_bus_sel", 32'(bus_sel), 32'd0);
    check32("rst_bus_addr", bus_addr, 32'd0);
    check32("rst_bus_wdata", bus_wdata, 32'd0);
    check32("rst_stallreq", 32'(stallreq), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    //      op          addr          reg2          wd  wr  ex_wdata     waits rdata         exp_wdata     we  bus_addr      sel      bus_wdata     st  brq err
    run_op(ADDU,       32'h0,        32'h0,        5,  1, 32'h12345678, 0,  32'h0,        32'h12345678, 0, 32'h0,        4'b0000, 32'h0,        0,  0, 0);
    run_op(EXE_LB_OP,  32'h103,      32'h0,        3,  1, 32'h103,      0,  32'h000000F0, 32'hFFFFFFF0, 0, 32'h100,      4'b0001, 32'h0,        2,  1, 0);
    run_op(EXE_LHU_OP, 32'h202,      32'h0,        4,  1, 32'h202,      3,  32'hAAAA8001, 32'h00008001, 0, 32'h200,      4'b0011, 32'h0,        5,  4, 0);
    run_op(EXE_SB_OP,  32'h1,        32'h000000AB, 0,  0, 32'h1,        0,  32'h0,        32'h1,        1, 32'h0,        4'b0100, 32'hABABABAB, 2,  1, 0);
    run_op(EXE_LW_OP,  32'h104,      32'h0,        7,  1, 32'h104,      99, 32'h0,        32'h0,        0, 32'h104,      4'b1111, 32'h0,        -1, 4, 1);
    run_op(EXE_SH_OP,  32'h6,        32'h1234CDEF, 0,  0, 32'h6,        1,  32'h0,        32'h6,        1, 32'h4,        4'b0011, 32'hCDEFCDEF, 3,  2, 0);
    run_op(EXE_LH_OP,  32'h8,        32'h0,        8,  1, 32'h8,        0,  32'h80017FFF, 32'hFFFF8001, 0, 32'h8,        4'b1100, 32'h0,        2,  1, 0);
    run_op(EXE_SW_OP,  32'hD,        32'hCAFEBABE, 0,  0, 32'hD,        0,  32'h0,        32'hD,        1, 32'hC,        4'b1111, 32'hCAFEBABE, 2,  1, 0);
    run_op(EXE_LBU_OP, 32'h12,       32'h0,        9,  1, 32'h12,       0,  32'h11229933, 32'h00000099, 0, 32'h10,       4'b0010, 32'h0,        2,  1, 0);
    run_op(EXE_LW_OP,  32'h1F,       32'h0,        10, 1, 32'h1F,       2,  32'h89ABCDEF, 32'h89ABCDEF, 0, 32'h1C,       4'b1111, 32'h0,        4,  3, 0);

    // reset dropped into the second BUSY cycle of a load
    @(posedge clk);
    #1;
    ex_valid = 1'b0; ex_aluop = EXE_LW_OP; ex_mem_addr = 32'h300;
    breqs = 0;
    for (int i = 0; i < 20 && breqs < 2; i++) begin
      @(negedge clk);
      if (bus_req) breqs++;
    end
    check32("rst_test_reached_busy2", 32'(breqs), 32'd2);
    rst = 1'b1;
    #1;
    check32("rst_mid_bus_req", 32'(bus_req), 32'd0);
    check32("rst_mid_stallreq", 32'(stallreq), 32'd0);
    check32("rst_mid_bus_sel", 32'(bus_sel), 32'd0);
    bus_ack = 1'b1;
    bus_rdata = 32'h5555_5555;
    @(posedge clk);
    #1;
    ex_aluop = NOP;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check32("late_ack_bus_req", 32'(bus_req), 32'd0);
      check32("late_ack_stallreq", 32'(stallreq), 32'd0);
      check32("late_ack_bus_err", 32'(bus_err), 32'd0);
    end
    bus_ack = 1'b0;

    run_op(EXE_LW_OP,  32'h20,       32'h0,        11, 1, 32'h20,       0,  32'h0BADF00D, 32'h0BADF00D, 0, 32'h20,       4'b1111, 32'h0,        2,  1, 0);

    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    ex_aluop = NOP;
    repeat (2) @(negedge clk);
    check32("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
